// File: rtl/wash_pkg.sv
// Shared types and default sizing for the inlet-valve fill arbiter.
// Imported by the interface, picker and arbiter.
package wash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam int N_MACH   = 4;
  localparam int MAX_FILL = 64;
  localparam int GAP_CYC  = 2;

endpackage

// File: rtl/fill_arbiter_if.sv
// Request/grant bundle between the washing machines and the arbiter.
// slave is the arbiter side, master the machine side.
interface fill_arbiter_if #(
  parameter int N_MACH = wash_pkg::N_MACH
);

  localparam int OW = (N_MACH > 1) ? $clog2(N_MACH) : 1;

  logic [N_MACH-1:0] fill_req;
  logic [N_MACH-1:0] fill_done;
  logic [N_MACH-1:0] fill_grant;
  logic              valve_open;
  logic [OW-1:0]     owner;
  logic [N_MACH-1:0] timeout;
  logic              busy;

  modport slave (
    input  fill_req,
    input  fill_done,
    output fill_grant,
    output valve_open,
    output owner,
    output timeout,
    output busy
  );

  modport master (
    output fill_req,
    output fill_done,
    input  fill_grant,
    input  valve_open,
    input  owner,
    input  timeout,
    input  busy
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin winner search: first eligible index above owner, with wrap.
// Purely combinational.
module rr_picker #(
  parameter int N_MACH = 4,
  parameter int OW     = 2
) (
  input  logic [N_MACH-1:0] elig,
  input  logic [OW-1:0]     owner,
  output logic [OW-1:0]     win,
  output logic              valid
);

  logic [OW-1:0] idx;

  // scan owner+1 .. owner+N_MACH, keep the first hit
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_MACH; k++) begin
      idx = OW'((int'(owner) + k) % N_MACH);
      if (!valid && elig[idx]) begin
        win   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fill_arbiter.sv
// Shared inlet valve arbiter: round-robin grant, bounded tenure,
// timeout lockout and a closed-valve gap between grants.
module fill_arbiter
  import wash_pkg::*;
#(
  parameter int N_MACH   = wash_pkg::N_MACH,
  parameter int MAX_FILL = wash_pkg::MAX_FILL,
  parameter int GAP_CYC  = wash_pkg::GAP_CYC
) (
  input logic           clk,
  input logic           reset,
  fill_arbiter_if.slave bus
);

  localparam int OW = (N_MACH > 1) ? $clog2(N_MACH) : 1;
  localparam int CW = (MAX_FILL > 1) ? $clog2(MAX_FILL) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_FILL - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [N_MACH-1:0] ONE = N_MACH'(1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     gcnt;
  logic [N_MACH-1:0] lockout;
  logic [N_MACH-1:0] grant;
  logic [N_MACH-1:0] tmo;
  logic [OW-1:0]     own;
  logic              valve;
  logic              bsy;

  logic [N_MACH-1:0] elig;
  logic [OW-1:0]     win;
  logic              valid;
  logic              hold;
  logic              rel;
  logic              expire;

  assign elig = bus.fill_req & ~bus.fill_done & ~lockout;

  // release on drop, done, or last tenure cycle; timeout only if held
  assign hold   = bus.fill_req[own] & ~bus.fill_done[own];
  assign rel    = ~hold | (cnt == CNT_LAST);
  assign expire = hold & (cnt == CNT_LAST);

  rr_picker #(
    .N_MACH (N_MACH),
    .OW     (OW)
  ) u_pick (
    .elig   (elig),
    .owner  (own),
    .win    (win),
    .valid  (valid)
  );

  // arbiter FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      lockout <= '0;
      grant   <= '0;
      tmo     <= '0;
      own     <= OW'(N_MACH - 1);
      valve   <= 1'b0;
      bsy     <= 1'b0;
    end else begin
      tmo     <= '0;
      lockout <= lockout & bus.fill_req;
      unique case (state)
        IDLE: begin
          if (valid) begin
            state <= GRANT;
            grant <= ONE << win;
            own   <= win;
            cnt   <= '0;
            valve <= 1'b1;
            bsy   <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            grant <= '0;
            valve <= 1'b0;
            cnt   <= '0;
            gcnt  <= '0;
            if (expire) begin
              tmo     <= ONE << own;
              lockout <= (lockout & bus.fill_req)
                       | (ONE << own);
            end
            if (GAP_CYC == 0) begin
              state <= IDLE;
              bsy   <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST) begin
            state <= IDLE;
            bsy   <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fill_grant = grant;
  assign bus.valve_open = valve;
  assign bus.owner      = own;
  assign bus.timeout    = tmo;
  assign bus.busy       = bsy;

endmodule

// File: doc/fill_arbiter.md
FILL_ARBITER -- requirements
Module: fill_arbiter

Interface
REQ-001 Parameter N_MACH, default 4: number of washing machines sharing one water inlet valve.
REQ-002 Parameter MAX_FILL, default 64: maximum grant tenure in cycles.
REQ-003 Parameter GAP_CYC, default 2: valve-closed cycles between consecutive grants (water-hammer guard).
REQ-004 Port clk  input  1: single clock; all state changes on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset.
REQ-006 Port fill_req  input  N_MACH: per-machine level request for inlet water.
REQ-007 Port fill_done  input  N_MACH: per-machine level-full indication; releases that machine's grant.
REQ-008 Port fill_grant  output  N_MACH: registered grant, one-hot or zero.
REQ-009 Port valve_open  output  1: registered inlet valve drive; high exactly when fill_grant is nonzero.
REQ-010 Port owner  output  clog2(N_MACH): index of the current or last granted machine.
REQ-011 Port timeout  output  N_MACH: one-cycle pulse on the machine whose grant hit MAX_FILL.
REQ-012 Port busy  output  1: high in GRANT or GAP state.

Function
REQ-013 FSM states: IDLE, GRANT, GAP; fill_grant nonzero only in GRANT.
REQ-014 IDLE: if any eligible request is present at an edge, the next state is GRANT and fill_grant is set to the round-robin winner at that same edge (one-cycle latency from request to grant).
REQ-015 Eligible request: fill_req[i]=1, fill_done[i]=0, and lockout[i]=0.
REQ-016 Round-robin: search starts at index owner+1 modulo N_MACH and proceeds upward with wrap; the first eligible index wins; owner updates to the winner at grant.
REQ-017 GRANT: tenure counter starts at 0 on grant and increments every cycle in GRANT.
REQ-018 Release in GRANT occurs when the owner drops fill_req, asserts fill_done, or the counter equals MAX_FILL-1; grant and valve drop at that edge, and the next state is GAP.
REQ-019 Timeout: if the counter reaches MAX_FILL-1 while the request is still held without fill_done, timeout[owner] pulses for one cycle at the release edge and lockout[owner] is set.
REQ-020 If fill_done or a request drop coincides with the counter reaching MAX_FILL-1, the release is a normal release: no timeout pulse and no lockout.
REQ-021 lockout[i] clears on the first edge at which fill_req[i]=0; a locked-out machine is never granted.
REQ-022 GAP: exactly GAP_CYC cycles with valve closed, then IDLE; requests arriving during GAP are held until IDLE and re-arbitrated there.
REQ-023 Minimum spacing between the falling edge and the next rising edge of valve_open is GAP_CYC+1 cycles.
REQ-024 A request from a non-owner during GRANT has no effect on the current grant (no preemption).
REQ-025 Counter width is clog2(MAX_FILL); the counter never wraps, because GRANT is left at MAX_FILL-1.
REQ-026 owner and lockout persist across IDLE and GAP.

Reset
REQ-027 On reset low, immediately: state IDLE, fill_grant=0, valve_open=0, timeout=0, busy=0, counter=0, lockout=0, owner=N_MACH-1, so that machine 0 has first priority.
REQ-028 Reset asserted mid-GRANT closes the valve asynchronously, with no GAP and no timeout pulse.
REQ-029 First grant occurs no earlier than one edge after reset deasserts.

Structure
REQ-030 Shared package wash_pkg holds the state enum (IDLE, GRANT, GAP) and the default constants N_MACH, MAX_FILL and GAP_CYC.
REQ-031 One combinational sub-module, rr_picker, takes the eligible mask and the owner and returns the winner index and a valid flag; fill_arbiter instantiates it once.

Verification
REQ-032 Reset, then fill_req=0001 -> fill_grant=0001 one edge later; fill_done[0] after 10 cycles -> grant 0, valve low for 2 cycles, busy low afterwards.
REQ-033 fill_req=1111 held, each grant released by fill_done after 3 cycles -> grant order 0,1,2,3,0 with 2-cycle valve-closed gaps.
REQ-034 Machine 2 holds fill_req with no fill_done -> grant lasts 64 cycles, timeout=0100 for one cycle, machine 2 is not regranted until it drops fill_req; machine 1 requesting is served next.
REQ-035 fill_done[1] at cycle 63 of tenure -> no timeout pulse and no lockout.
REQ-036 Reset pulled low during a grant to machine 3 -> valve_open and fill_grant go to 0 without a clock edge; after release, fill_req=1000 -> machine 3 is granted.
REQ-037 Machine 0 in GRANT while machine 1 requests -> no change to fill_grant until machine 0 releases; machine 1 is granted after the gap, with at least 3 cycles between valve falling and rising.
